// File: rtl/opb_register_simulink2ppc.sv
// OPB slave exposing a fabric-written 32-bit word to the PPC, with new/overrun
// flags, a 16-bit update counter and a freeze control that blocks captures.
module opb_register_simulink2ppc #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter string       C_FAMILY     = "virtex5"
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [31:0]             user_data_in,
  input  logic                    user_data_valid
);

  localparam logic [0:0] st_idle = 1'b0;
  localparam logic [0:0] st_ack  = 1'b1;

  logic [0:0]  state;
  logic [2:0]  off_q;
  logic        rnw_q;
  logic [31:0] data_reg;
  logic        new_flag;
  logic        ovr_flag;
  logic        freeze;
  logic [15:0] count;
  logic        hit;
  logic        ack;
  logic        capture;
  logic        data_rd_ack;
  logic        ctrl_wr;
  logic [31:0] rd_word;
  logic        unused_bits;

  // Offset from base compared against the window span: one unsigned compare
  // covers both bounds because addresses below base wrap to large values.
  assign hit         = OPB_select && ((OPB_ABus - C_BASEADDR) <= (C_HIGHADDR - C_BASEADDR));
  assign ack         = (state == st_ack);
  assign capture     = user_data_valid && !freeze;
  assign data_rd_ack = ack && rnw_q && (off_q == 3'd0);
  assign ctrl_wr     = ack && !rnw_q && (off_q == 3'd2) && OPB_BE[3];

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state <= st_idle;
      off_q <= 3'd0;
      rnw_q <= 1'b0;
    end else if (state == st_idle && hit) begin
      state <= st_ack;
      off_q <= OPB_ABus[27:29];
      rnw_q <= OPB_RNW;
    end else begin
      state <= st_idle;
    end
  end

  // A capture in the same cycle as a DATA read keeps new set but clears
  // overrun, since the word that was overwritten has just been consumed.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      data_reg <= 32'h0;
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
      count    <= 16'h0;
    end else if (capture) begin
      data_reg <= user_data_in;
      count    <= count + 16'd1;
      new_flag <= 1'b1;
      ovr_flag <= data_rd_ack ? 1'b0 : (ovr_flag | new_flag);
    end else if (data_rd_ack) begin
      new_flag <= 1'b0;
      ovr_flag <= 1'b0;
    end
  end

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      freeze <= 1'b0;
    end else if (ctrl_wr) begin
      freeze <= OPB_DBus[31];
    end
  end

  always_comb begin
    rd_word = 32'h0;
    case (off_q)
      3'd0:    rd_word = data_reg;
      3'd1:    rd_word = {new_flag, ovr_flag, freeze, 13'b0, count};
      3'd2:    rd_word = {31'b0, freeze};
      default: rd_word = 32'h0;
    endcase
  end

  assign Sl_DBus    = (ack && rnw_q) ? rd_word : '0;
  assign Sl_xferAck = ack;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign unused_bits = &{1'b0, OPB_seqAddr, OPB_DBus[0:30], OPB_BE[0:2]};

  // Family is informational; referenced here only so it is not dangling.
  if (C_FAMILY == "") begin : g_family_unset
  end

endmodule

// File: tb/tb_opb_register_simulink2ppc.sv
// Directed bench for opb_register_simulink2ppc: transaction-level model of the
// register contents plus a per-cycle monitor checking bus outputs against it.
module tb_opb_register_simulink2ppc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [0:31] abus = '0;
  logic [0:3]  be = '0;
  logic [0:31] dbus_w = '0;
  logic        rnw = 1'b0;
  logic        sel = 1'b0;
  logic        seq_addr = 1'b0;
  logic [0:31] dbus_r;
  logic        xfer_ack, err_ack, retry, tout_sup;
  logic [31:0] user_data = '0;
  logic        user_valid = 1'b0;

  int errors = 0;
  int checks = 0;

  // model of the register contents
  logic [31:0] m_data = '0;
  bit          m_new = 0, m_ovr = 0, m_freeze = 0;
  logic [15:0] m_count = '0;

  logic [31:0] exp_rd = '0;
  bit          exp_valid = 0;
  bit          prev_ack = 0;

  always #5 clk = ~clk;

  opb_register_simulink2ppc dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_w),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq_addr),
    .Sl_DBus(dbus_r), .Sl_xferAck(xfer_ack), .Sl_errAck(err_ack), .Sl_retry(retry),
    .Sl_toutSup(tout_sup), .user_data_in(user_data), .user_data_valid(user_valid)
  );

  function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] addr);
    case ((addr >> 2) & 32'd7)
      32'd0:   return m_data;
      32'd1:   return (32'(m_new) << 31) + (32'(m_ovr) << 30) + (32'(m_freeze) << 29) + 32'(m_count);
      32'd2:   return 32'(m_freeze);
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_reset();
    m_data = '0; m_new = 0; m_ovr = 0; m_freeze = 0; m_count = '0;
  endfunction

  function automatic void model_strobe(input logic [31:0] d, input bit consumed);
    if (m_freeze) begin
      if (consumed) begin m_new = 0; m_ovr = 0; end
      return;
    end
    m_data  = d;
    m_count = m_count + 16'd1;
    m_ovr   = consumed ? 1'b0 : (m_ovr | m_new);
    m_new   = 1;
  endfunction

  always @(negedge clk) begin
    chk("tie_errack", 32'(err_ack), 32'h0);
    chk("tie_retry", 32'(retry), 32'h0);
    chk("tie_toutsup", 32'(tout_sup), 32'h0);
    chk("ack_back_to_back", 32'(prev_ack & xfer_ack), 32'h0);
    if (!xfer_ack) chk("dbus_idle_zero", dbus_r, 32'h0);
    else if (exp_valid) chk("rd_data_model", dbus_r, exp_rd);
    prev_ack = xfer_ack;
  end

  task automatic wait_first_ack();
    @(posedge clk); #1;
    chk("ack_latency", 32'(xfer_ack), 32'h1);
    for (int i = 0; i < 8 && !xfer_ack; i++) begin
      @(posedge clk); #1;
    end
    if (!xfer_ack) chk("ack_timeout", 32'(xfer_ack), 32'h1);
  endtask

  task automatic bus_read(input logic [31:0] addr, input bit strobe_in_ack,
                          input logic [31:0] sdata, output logic [31:0] got);
    bit is_data;
    @(negedge clk);
    exp_rd = model_word(addr); exp_valid = 1;
    abus = addr; rnw = 1'b1; sel = 1'b1;
    wait_first_ack();
    got = dbus_r;
    sel = 1'b0;
    if (strobe_in_ack) begin user_data = sdata; user_valid = 1'b1; end
    @(posedge clk); #1;
    chk("ack_one_cycle", 32'(xfer_ack), 32'h0);
    user_valid = 1'b0; exp_valid = 0;
    is_data = (((addr >> 2) & 32'd7) == 32'd0);
    if (strobe_in_ack) model_strobe(sdata, is_data);
    else if (is_data) begin m_new = 0; m_ovr = 0; end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [0:3] wbe, input logic [31:0] data);
    @(negedge clk);
    abus = addr; rnw = 1'b0; be = wbe; dbus_w = data; sel = 1'b1;
    wait_first_ack();
    sel = 1'b0;
    @(posedge clk); #1;
    chk("wr_ack_one_cycle", 32'(xfer_ack), 32'h0);
    dbus_w = '0; be = '0;
    if (((addr >> 2) & 32'd7) == 32'd2 && wbe[3]) m_freeze = data[0];
  endtask

  task automatic strobe(input logic [31:0] d);
    @(negedge clk);
    user_data = d; user_valid = 1'b1;
    @(negedge clk);
    user_valid = 1'b0;
    model_strobe(d, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  logic [31:0] rd;

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset_ack", 32'(xfer_ack), 32'h0);

    // 1: reset values
    bus_read(32'h0, 0, 0, rd); chk("t1_data", rd, 32'h0);
    bus_read(32'h4, 0, 0, rd); chk("t1_status", rd, 32'h0);
    bus_read(32'h8, 0, 0, rd); chk("t1_ctrl", rd, 32'h0);
    bus_read(32'hC, 0, 0, rd); chk("t1_unmapped", rd, 32'h0);

    // out-of-window access is not acknowledged
    @(negedge clk);
    abus = 32'h100; rnw = 1'b1; sel = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      chk("miss_no_ack", 32'(xfer_ack), 32'h0);
    end
    sel = 1'b0;

    // 2: single capture then consume
    do_reset();
    strobe(32'hDEADBEEF);
    bus_read(32'h4, 0, 0, rd); chk("t2_status_new", rd, 32'h80000001);
    bus_read(32'h0, 0, 0, rd); chk("t2_data", rd, 32'hDEADBEEF);
    bus_read(32'h4, 0, 0, rd); chk("t2_status_after", rd, 32'h00000001);

    // 3: overrun
    do_reset();
    strobe(32'h11);
    strobe(32'h22);
    bus_read(32'h4, 0, 0, rd); chk("t3_status_ovr", rd, 32'hC0000002);
    bus_read(32'h0, 0, 0, rd); chk("t3_data", rd, 32'h22);
    bus_read(32'h4, 0, 0, rd); chk("t3_status_after", rd, 32'h00000002);

    // 4: freeze control and byte enables
    do_reset();
    bus_write(32'h8, 4'b0001, 32'h1);
    strobe(32'h55);
    bus_read(32'h4, 0, 0, rd); chk("t4_status_frozen", rd, 32'h20000000);
    bus_read(32'h0, 0, 0, rd); chk("t4_data_unchanged", rd, 32'h0);
    bus_read(32'h8, 0, 0, rd); chk("t4_ctrl_set", rd, 32'h1);
    bus_write(32'h8, 4'b0001, 32'h0);
    bus_write(32'h8, 4'b1110, 32'h1);
    bus_read(32'h8, 0, 0, rd); chk("t4_ctrl_be_masked", rd, 32'h0);
    strobe(32'h66);
    bus_read(32'h4, 0, 0, rd); chk("t4_status_unfrozen", rd, 32'h80000001);

    // 5: capture coincident with a DATA read ack
    do_reset();
    strobe(32'hA);
    bus_read(32'h0, 1, 32'hB, rd); chk("t5_data_old", rd, 32'hA);
    bus_read(32'h4, 0, 0, rd); chk("t5_status", rd, 32'h80000002);
    bus_read(32'h0, 0, 0, rd); chk("t5_data_new", rd, 32'hB);

    // 6: counter wrap
    do_reset();
    @(negedge clk);
    user_valid = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      user_data = 32'(i);
      @(negedge clk);
      model_strobe(32'(i), 0);
    end
    user_valid = 1'b0;
    bus_read(32'h4, 0, 0, rd); chk("t6_count_ffff", rd, 32'hC000FFFF);
    strobe(32'h77);
    bus_read(32'h4, 0, 0, rd); chk("t6_count_wrap", rd, 32'hC0000000);

    // reset asserted while acking
    @(negedge clk);
    abus = 32'h4; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    chk("rst_pre_ack", 32'(xfer_ack), 32'h1);
    rst = 1'b1;
    #1;
    chk("rst_ack_drop", 32'(xfer_ack), 32'h0);
    chk("rst_dbus_drop", dbus_r, 32'h0);
    sel = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    bus_read(32'h4, 0, 0, rd); chk("rst_status_clear", rd, 32'h0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
